// File: rtl/m68k_bus_responder_if.sv
// Initiator-side strobes, address and status of the 68000 bus responder.
// The data bus and open-drain DTACK/VPA stay as module ports so they resolve on the board net.
interface m68k_bus_responder_if;
    logic [22:0] M68K_A;
    logic        M68K_AS_n;
    logic        M68K_UDS_n;
    logic        M68K_LDS_n;
    logic        M68K_RW;
    logic        M68K_VMA_n;
    logic        M68K_E;
    logic        BUS_HIT;
    logic [15:0] ACC_CNT;

    modport master (
        output M68K_A, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n, M68K_E,
        input  BUS_HIT, ACC_CNT
    );

    modport slave (
        input  M68K_A, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_VMA_n, M68K_E,
        output BUS_HIT, ACC_CNT
    );
endinterface

// File: rtl/m68k_bus_responder.sv
// 68000 asynchronous-bus target: 2**WINDOW_BITS-word register RAM answered with DTACK after
// WAIT_STATES clocks. Define M68K_RESP_VPA_EN to add a 6800-style VPA/VMA/E window at VPA_BASE.
module m68k_bus_responder #(
    parameter logic [22:0] BASE_ADDR   = 23'h7E0000,
`ifdef M68K_RESP_VPA_EN
    parameter logic [22:0] VPA_BASE    = 23'h7F0000,
`endif
    parameter int unsigned WINDOW_BITS = 6,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                       M68K_CLK,
    input  logic                       M68K_RST,
    m68k_bus_responder_if.slave        bus,
    inout  wire  [15:0]                M68K_D,
    output wire                        M68K_DTACK_n,
    output wire                        M68K_VPA_n
);

    localparam int unsigned Words    = 2 ** WINDOW_BITS;
    localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StWait,
        StAck,
        StIgnore,
        StVpa
    } state_e;

    state_e                   state_q;
    logic [3:0]               cnt_q;
    logic                     as_q;
    logic                     uds_q;
    logic                     lds_q;
    logic                     rw_q;
    logic                     dtack_q;
    logic                     d_oe_q;
    logic                     bus_hit_q;
    logic [15:0]              acc_cnt_q;
    logic [15:0]              mem [Words];

    logic [WINDOW_BITS-1:0]   idx;
    logic [15:0]              rd_data;
    logic                     dtack_hit;
    logic                     ack_enter;
    logic                     cnt_inc;
    logic                     mem_we;

    assign idx       = bus.M68K_A[WINDOW_BITS-1:0];
    assign rd_data   = mem[idx];
    assign dtack_hit = bus.M68K_A[22:WINDOW_BITS] == BASE_ADDR[22:WINDOW_BITS];

`ifdef M68K_RESP_VPA_EN
    logic vma_q;
    logic e_q;
    logic e_prev_q;
    logic vpa_q;
    logic e_done_q;
    logic vpa_hit;
    logic vpa_strobe;

    assign vpa_hit = bus.M68K_A[22:WINDOW_BITS] == VPA_BASE[22:WINDOW_BITS];
`else
    logic unused_vpa_in;
    assign unused_vpa_in = ^{bus.M68K_VMA_n, bus.M68K_E};
`endif

    always_comb begin
        ack_enter = 1'b0;
        if (!as_q) begin
            if (state_q == StDecode && dtack_hit && WAIT_STATES == 0) ack_enter = 1'b1;
            if (state_q == StWait && cnt_q == 4'd0)                   ack_enter = 1'b1;
        end
        cnt_inc = ack_enter;
        mem_we  = ack_enter && !rw_q;
`ifdef M68K_RESP_VPA_EN
        // One 6800 transfer per VPA cycle, committed on the E falling edge.
        vpa_strobe = (state_q == StVpa) && !as_q && !vma_q && e_prev_q && !e_q && !e_done_q;
        cnt_inc    = cnt_inc || vpa_strobe;
        mem_we     = mem_we || (vpa_strobe && !rw_q);
`endif
    end

    always_ff @(posedge M68K_CLK) begin
        if (M68K_RST) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            as_q      <= 1'b1;
            uds_q     <= 1'b1;
            lds_q     <= 1'b1;
            rw_q      <= 1'b1;
            dtack_q   <= 1'b0;
            d_oe_q    <= 1'b0;
            bus_hit_q <= 1'b0;
            acc_cnt_q <= 16'd0;
`ifdef M68K_RESP_VPA_EN
            vma_q     <= 1'b1;
            e_q       <= 1'b0;
            e_prev_q  <= 1'b0;
            vpa_q     <= 1'b0;
            e_done_q  <= 1'b0;
`endif
        end else begin
            as_q  <= bus.M68K_AS_n;
            uds_q <= bus.M68K_UDS_n;
            lds_q <= bus.M68K_LDS_n;
            rw_q  <= bus.M68K_RW;
`ifdef M68K_RESP_VPA_EN
            vma_q    <= bus.M68K_VMA_n;
            e_q      <= bus.M68K_E;
            e_prev_q <= e_q;
`endif

            unique case (state_q)
                StIdle: begin
                    // Wait for a data strobe too, so writes latch valid data.
                    if (!as_q && (!uds_q || !lds_q)) state_q <= StDecode;
                end

                StDecode: begin
                    if (as_q) begin
                        state_q <= StIdle;
                    end else if (dtack_hit) begin
                        bus_hit_q <= 1'b1;
                        d_oe_q    <= rw_q;
                        if (WAIT_STATES == 0) begin
                            state_q <= StAck;
                            dtack_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitInit;
                        end
                    end
`ifdef M68K_RESP_VPA_EN
                    else if (vpa_hit) begin
                        state_q   <= StVpa;
                        bus_hit_q <= 1'b1;
                        vpa_q     <= 1'b1;
                        e_done_q  <= 1'b0;
                    end
`endif
                    else begin
                        state_q <= StIgnore;
                    end
                end

                StWait: begin
                    if (as_q) begin
                        state_q   <= StIdle;
                        d_oe_q    <= 1'b0;
                        bus_hit_q <= 1'b0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= StAck;
                        dtack_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                StAck: begin
                    if (as_q) begin
                        state_q   <= StIdle;
                        dtack_q   <= 1'b0;
                        d_oe_q    <= 1'b0;
                        bus_hit_q <= 1'b0;
                    end
                end

                StIgnore: begin
                    if (as_q) state_q <= StIdle;
                end

`ifdef M68K_RESP_VPA_EN
                StVpa: begin
                    if (as_q) begin
                        state_q   <= StIdle;
                        vpa_q     <= 1'b0;
                        d_oe_q    <= 1'b0;
                        bus_hit_q <= 1'b0;
                    end else begin
                        if (!vma_q && e_q && !e_prev_q && rw_q) d_oe_q <= 1'b1;
                        if (vpa_strobe) e_done_q <= 1'b1;
                    end
                end
`endif

                default: state_q <= StIdle;
            endcase

            if (cnt_inc) acc_cnt_q <= acc_cnt_q + 16'd1;
            if (mem_we) begin
                if (!uds_q) mem[idx][15:8] <= M68K_D[15:8];
                if (!lds_q) mem[idx][7:0]  <= M68K_D[7:0];
            end
        end
    end

    assign M68K_D       = d_oe_q ? rd_data : 16'hzzzz;
    assign M68K_DTACK_n = dtack_q ? 1'b0 : 1'bz;
`ifdef M68K_RESP_VPA_EN
    assign M68K_VPA_n   = vpa_q ? 1'b0 : 1'bz;
`else
    assign M68K_VPA_n   = 1'bz;
`endif
    assign bus.BUS_HIT  = bus_hit_q;
    assign bus.ACC_CNT  = acc_cnt_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: two responders (2 and 4 wait states) on separate windows,
// directed vector table, hand-written abort/reset/VPA sequences and random cycles vs a model.
module tb_m68k_bus_responder;
    localparam logic [22:0] BASE_A = 23'h7E0000;
    localparam logic [22:0] BASE_B = 23'h100000;
    localparam logic [22:0] VPA_A  = 23'h7F0000;
    localparam logic [22:0] VPA_B  = 23'h110000;
    localparam int unsigned WS_A   = 2;
    localparam int unsigned WS_B   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [22:0] a = '0;
    logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1, vma_n = 1'b1, e = 1'b0;
    logic [15:0] d_drv = '0;
    logic        d_oe = 1'b0;
    int          sel = 0;

    always #70 clk = ~clk;

    m68k_bus_responder_if bus_a ();
    m68k_bus_responder_if bus_b ();

    assign bus_a.M68K_A = a;      assign bus_b.M68K_A = a;
    assign bus_a.M68K_AS_n = as_n;  assign bus_b.M68K_AS_n = as_n;
    assign bus_a.M68K_UDS_n = uds_n; assign bus_b.M68K_UDS_n = uds_n;
    assign bus_a.M68K_LDS_n = lds_n; assign bus_b.M68K_LDS_n = lds_n;
    assign bus_a.M68K_RW = rw;    assign bus_b.M68K_RW = rw;
    assign bus_a.M68K_VMA_n = vma_n; assign bus_b.M68K_VMA_n = vma_n;
    assign bus_a.M68K_E = e;      assign bus_b.M68K_E = e;

    tri1 [15:0] d_a, d_b;
    tri1        dtack_a, dtack_b, vpa_a, vpa_b;
    assign d_a = d_oe ? d_drv : 16'hzzzz;
    assign d_b = d_oe ? d_drv : 16'hzzzz;

    m68k_bus_responder #(
        .BASE_ADDR  (BASE_A),
`ifdef M68K_RESP_VPA_EN
        .VPA_BASE   (VPA_A),
`endif
        .WINDOW_BITS(6),
        .WAIT_STATES(WS_A)
    ) u_dut_a (
        .M68K_CLK    (clk),
        .M68K_RST    (rst),
        .bus         (bus_a),
        .M68K_D      (d_a),
        .M68K_DTACK_n(dtack_a),
        .M68K_VPA_n  (vpa_a)
    );

    m68k_bus_responder #(
        .BASE_ADDR  (BASE_B),
`ifdef M68K_RESP_VPA_EN
        .VPA_BASE   (VPA_B),
`endif
        .WINDOW_BITS(6),
        .WAIT_STATES(WS_B)
    ) u_dut_b (
        .M68K_CLK    (clk),
        .M68K_RST    (rst),
        .bus         (bus_b),
        .M68K_D      (d_b),
        .M68K_DTACK_n(dtack_b),
        .M68K_VPA_n  (vpa_b)
    );

    wire        dtack_s = (sel == 1) ? dtack_b : dtack_a;
    wire        vpa_s   = (sel == 1) ? vpa_b : vpa_a;
    wire [15:0] d_s     = (sel == 1) ? d_b : d_a;
    wire        hit_s   = (sel == 1) ? bus_b.BUS_HIT : bus_a.BUS_HIT;
    wire [15:0] cnt_s   = (sel == 1) ? bus_b.ACC_CNT : bus_a.ACC_CNT;

    // Reference model: per-window word store, whole-word validity, completed-cycle counts.
    logic [22:0] mdl_base [2] = '{BASE_A, BASE_B};
    int          mdl_ws   [2] = '{WS_A, WS_B};
    logic [15:0] mdl_mem  [2][64];
    bit          mdl_val  [2][64];
    int unsigned mdl_cnt  [2] = '{0, 0};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit mdl_hit(input int s, input logic [22:0] addr);
        return (addr >> 6) == (mdl_base[s] >> 6);
    endfunction

    task automatic mdl_update(input logic [22:0] addr, input logic wr, input logic un,
                              input logic ln, input logic [15:0] wdata);
        int k;
        logic [15:0] w;
        for (int s = 0; s < 2; s++) begin
            if (mdl_hit(s, addr)) begin
                mdl_cnt[s] = (mdl_cnt[s] + 1) % 65536;
                if (wr) begin
                    k = int'(addr % 64);
                    w = mdl_mem[s][k];
                    if (!un) w = (w & 16'h00FF) | (wdata & 16'hFF00);
                    if (!ln) w = (w & 16'hFF00) | (wdata & 16'h00FF);
                    mdl_mem[s][k] = w;
                    if (!un && !ln) mdl_val[s][k] = 1'b1;
                end
            end
        end
    endtask

    // One complete 68000 cycle; outputs of DUT s are checked edge by edge.
    task automatic bus_cycle(input int s, input logic [22:0] addr, input logic wr,
                             input logic un, input logic ln, input logic [15:0] wdata,
                             input logic chk_rd, input logic [15:0] exp_rd, input string tag);
        bit hit;
        int lat;
        int early;
        int vpa_seen;
        sel = s;
        hit = mdl_hit(s, addr);
        lat = 2 + mdl_ws[s];
        early = 0;
        vpa_seen = 0;
        @(negedge clk);
        a = addr; rw = !wr; d_drv = wdata; d_oe = wr; uds_n = un; lds_n = ln; as_n = 1'b0;
        @(posedge clk); #1;
        for (int j = 1; j <= lat; j++) begin
            @(posedge clk); #1;
            if (!vpa_s) vpa_seen++;
            if (j < lat && !dtack_s) early++;
            if (j == 2 && hit && !wr && chk_rd && mdl_ws[s] > 0)
                check({tag, "_rd_wait"}, d_s, exp_rd);
        end
        check({tag, "_dtack"}, dtack_s, !hit);
        check({tag, "_early"}, early, 0);
        check({tag, "_hit"}, hit_s, hit);
        if (!wr && !hit) check({tag, "_d_z"}, d_s, 16'hFFFF);
        if (!wr && hit && chk_rd) check({tag, "_rd"}, d_s, exp_rd);
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(posedge clk); #1;
        if (hit) check({tag, "_hold"}, dtack_s, 0);
        @(posedge clk); #1;
        if (!vpa_s) vpa_seen++;
        check({tag, "_release"}, dtack_s, 1);
        check({tag, "_hit_rel"}, hit_s, 0);
        if (!wr) check({tag, "_d_rel"}, d_s, 16'hFFFF);
        check({tag, "_vpa"}, vpa_seen, 0);
        @(negedge clk);
        d_oe = 1'b0;
        mdl_update(addr, wr, un, ln, wdata);
        check({tag, "_cnt"}, cnt_s, mdl_cnt[s]);
    endtask

    typedef struct {
        int          s;
        logic [22:0] addr;
        logic        wr;
        logic        un;
        logic        ln;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp_rd;
        string       tag;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int early;
        int vpa_at;
        int kind;
        int s;
        int k;
        logic [22:0] addr;
        logic wr, un, ln;
        int lanes;

        vecs[0] = '{0, 23'h7E0002, 1'b1, 1'b0, 1'b0, 16'hA55A, 1'b0, 16'h0000, "wr_word"};
        vecs[1] = '{0, 23'h7E0002, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA55A, "rd_word"};
        vecs[2] = '{0, 23'h7E0002, 1'b1, 1'b1, 1'b0, 16'h12FF, 1'b0, 16'h0000, "wr_lds"};
        vecs[3] = '{0, 23'h7E0002, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA5FF, "rd_lds"};
        vecs[4] = '{0, 23'h000100, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, "miss"};
        vecs[5] = '{1, 23'h100005, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, "b_wr"};
        vecs[6] = '{1, 23'h100005, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, "b_rd"};
        vecs[7] = '{0, 23'h7E003F, 1'b1, 1'b0, 1'b0, 16'h8001, 1'b0, 16'h0000, "wr_top"};
        vecs[8] = '{0, 23'h7E003F, 1'b1, 1'b0, 1'b1, 16'h7F55, 1'b0, 16'h0000, "wr_uds"};
        vecs[9] = '{0, 23'h7E003F, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7F01, "rd_uds"};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_dtack_a", dtack_a, 1);
        check("rst_dtack_b", dtack_b, 1);
        check("rst_vpa_a", vpa_a, 1);
        check("rst_d_a", d_a, 16'hFFFF);
        check("rst_d_b", d_b, 16'hFFFF);
        check("rst_cnt_a", bus_a.ACC_CNT, 0);
        check("rst_cnt_b", bus_b.ACC_CNT, 0);
        check("rst_hit_a", bus_a.BUS_HIT, 0);
        check("rst_hit_b", bus_b.BUS_HIT, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            bus_cycle(vecs[i].s, vecs[i].addr, vecs[i].wr, vecs[i].un, vecs[i].ln,
                      vecs[i].wdata, vecs[i].chk, vecs[i].exp_rd, vecs[i].tag);

        // Abort: write of 0000 on the 4-wait-state window, AS negated right after DECODE
        sel = 1;
        @(negedge clk);
        a = 23'h100005; rw = 1'b0; d_drv = 16'h0000; d_oe = 1'b1;
        uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        early = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (!dtack_b) early++;
        end
        check("abort_dtack", early, 0);
        check("abort_hit", bus_b.BUS_HIT, 0);
        check("abort_cnt", bus_b.ACC_CNT, mdl_cnt[1]);
        @(negedge clk);
        d_oe = 1'b0;
        bus_cycle(1, 23'h100005, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, "post_abort");

        // Reset in the middle of a write drops it
        bus_cycle(0, 23'h7E000A, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b0, 16'h0000, "pre_rst_wr");
        sel = 0;
        @(negedge clk);
        a = 23'h7E000A; rw = 1'b0; d_drv = 16'hBEEF; d_oe = 1'b1;
        uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_hit", bus_a.BUS_HIT, 1);
        @(negedge clk);
        rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_dtack", dtack_a, 1);
        check("rst_mid_hit0", bus_a.BUS_HIT, 0);
        check("rst_mid_cnt", bus_a.ACC_CNT, 0);
        @(negedge clk);
        rst = 1'b0; d_oe = 1'b0;
        mdl_cnt[0] = 0;
        mdl_cnt[1] = 0;
        bus_cycle(0, 23'h7E000A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, "rst_drop");

`ifdef M68K_RESP_VPA_EN
        // 6800-style read of word 2 through the VPA window
        sel = 0;
        @(negedge clk);
        a = VPA_A + 23'd2; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; vma_n = 1'b1; e = 1'b0;
        as_n = 1'b0;
        @(posedge clk); #1;
        vpa_at = -1;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
            if (!vpa_a && vpa_at < 0) vpa_at = j;
        end
        check("vpa_lat", vpa_at, 2);
        check("vpa_no_dtack", dtack_a, 1);
        check("vpa_hit", bus_a.BUS_HIT, 1);
        @(negedge clk);
        vma_n = 1'b0;
        @(negedge clk);
        e = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("vpa_rd", d_a, mdl_mem[0][2]);
        @(negedge clk);
        e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mdl_cnt[0] = (mdl_cnt[0] + 1) % 65536;
        check("vpa_cnt", bus_a.ACC_CNT, mdl_cnt[0]);
        check("vpa_rd_hold", d_a, mdl_mem[0][2]);
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; vma_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("vpa_rel", vpa_a, 1);
        check("vpa_d_rel", d_a, 16'hFFFF);
        check("vpa_hit_rel", bus_a.BUS_HIT, 0);
        @(negedge clk);
`else
        bus_cycle(0, VPA_A + 23'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, "vpa_off");
`endif

        // Random cycles against the model
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            k = $urandom_range(0, 63);
            wr = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                s = 0; addr = BASE_A + 23'(k);
            end else if (kind == 1) begin
                s = 1; addr = BASE_B + 23'(k);
            end else begin
                s = $urandom_range(0, 1); addr = 23'($urandom_range(0, 23'h0FFFFF));
            end
            lanes = wr ? $urandom_range(0, 2) : 0;
            un = (lanes == 2);
            ln = (lanes == 1);
            bus_cycle(s, addr, wr, un, ln, 16'($urandom), 1'(mdl_val[s][k]),
                      mdl_mem[s][k], "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/m68k_bus_responder.md
# m68k_bus_responder

- 68000 asynchronous-bus target that decodes its own address window and answers initiator cycles on the Amiga-side bus.
- Serves a 64-word internal register RAM with a configurable number of wait states before DTACK.
- Used as the opposite end of the Pistorm'X bus master: bench/loopback target for the CPLD initiator, and a template for on-board peripherals.
- Optionally answers a second window as a 6800-style VPA/VMA/E peripheral.

## Interface
- BASE_ADDR, 23'h7E0000: A[23:1] base of DTACK window; A[23:1+WINDOW_BITS] compared.
- WINDOW_BITS, 6: log2 of word count in window (64 words).
- WAIT_STATES, 2: clocks inserted between DECODE and DTACK assertion (0..15).
- VPA_BASE, 23'h7F0000: A[23:1] base of VPA window, same size; only with VPA build option.
- M68K_CLK  in  1  7.09 MHz bus clock; all logic on rising edge.
- M68K_RST  in  1  reset, synchronous, active-high.
- M68K_A  in  23  address A[23:1].
- M68K_D  inout  16  data bus; driven only for read hits.
- M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW  in  1 each  bus strobes, RW=1 read.
- M68K_DTACK_n  out  1  0 in ACK, else Z.
- M68K_VPA_n  out  1  0 during VPA cycle, else Z.
- M68K_VMA_n, M68K_E  in  1 each  6800 handshake from initiator.
- BUS_HIT  out  1  high from DECODE hit until return to IDLE.
- ACC_CNT  out  16  completed-cycle counter.

## Operation
- Inputs AS/UDS/LDS/RW/VMA/E registered once (as_q etc.) before use; A and D used directly while state holds.
- States: IDLE, DECODE, WAIT, ACK, IGNORE, VPA (build option).
- IDLE -> DECODE when as_q=0 and (uds_q=0 or lds_q=0); DS low required so writes see valid data.
- DECODE: DTACK-window hit -> WAIT with cnt=WAIT_STATES-1, or ACK directly if WAIT_STATES=0; VPA-window hit -> VPA; miss -> IGNORE.
- WAIT: cnt decrements; at cnt=0 -> ACK. ACK entry: write hits store D[15:8] if uds_q=0, D[7:0] if lds_q=0; ACC_CNT += 1.
- ACK, IGNORE: hold until as_q=1 -> IDLE.
- Read hit: M68K_D driven with mem[A[WINDOW_BITS:1]] in WAIT and ACK; Z in every other state and for writes.
- as_q=1 in DECODE or WAIT (aborted cycle): -> IDLE, no write, no count, DTACK never asserted.
- ACC_CNT wraps 16'hFFFF -> 0.
- RAM contents unaffected by reset.
- Reset: state=IDLE, DTACK_n=Z, VPA_n=Z, D=Z, BUS_HIT=0, ACC_CNT=0, cnt=0. Reset mid-cycle abandons it; any pending write is dropped.

## Timing
- AS and DS sampled low at edge n: DECODE after n+1, DTACK_n low after edge n+2+WAIT_STATES.
- DTACK_n, M68K_D and BUS_HIT release after the first edge where ACK sees as_q=1 (two edges after AS rises).
- Read data stable from WAIT entry, at least one clock before DTACK.
- Initiator samples DTACK at its S3/S4 boundary: WAIT_STATES=0 gives a zero-extra-wait access at 7 MHz; each wait state adds one clock.
- Back-to-back cycles: IDLE needs as_q=1 for one sample before accepting the next AS.

## Configuration
- M68K_RESP_VPA_EN defined:
  - VPA state built; VPA_BASE window active.
  - In VPA: VPA_n=0.
  - Once vma_q=0, read data driven from the next rising E (e_q 0->1) until AS high.
  - Write captured on E falling (e_q 1->0) with vma_q=0; ACC_CNT increments at that E fall, for reads and writes.
  - Exit to IDLE on as_q=1.
- M68K_RESP_VPA_EN not defined: no VPA logic; M68K_VPA_n constant Z; VPA_BASE hits treated as misses (IGNORE).

## Test plan
- Reset: assert M68K_RST 2 clocks -> DTACK_n, VPA_n, D all Z; ACC_CNT=0; BUS_HIT=0.
- Word write 16'hA55A to BASE_ADDR+4 (A=23'h7E0002), then word read same address, WAIT_STATES=2 -> read returns 16'hA55A; DTACK low 4 edges after AS/DS sample; ACC_CNT=2.
- Byte write LDS only, D=16'h12FF to a word holding 16'hA55A -> read returns 16'hA5FF.
- Miss at 23'h000100 -> DTACK_n and D remain Z for the whole cycle; ACC_CNT unchanged.
- Abort: AS negated one clock after DECODE with WAIT_STATES=4, write 16'h0000 -> no DTACK, memory unchanged, count unchanged; next cycle completes normally.
- M68K_RESP_VPA_EN: read VPA_BASE with initiator asserting VMA at e_counter=2 -> VPA_n low, data valid by E rise, cycle ends on AS negate; ACC_CNT +1.
